// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: round-robin writeback arbiter feeding the ROB write ports.
// Ports: clk, rst_aL (sync, active-low), flush; req_valid/req_ready/req_addr/
// req_data per requester; registered wr_en/wr_addr/wr_data per ROB port;
// rr_ptr and grant_count are debug views.
module rob_wb_arbiter #(
    parameter  int N_REQ         = 4,
    parameter  int N_WRITE_PORTS = 2,
    parameter  int ENTRY_WIDTH   = 32,
    parameter  int N_ENTRIES     = 8,
    localparam int PTR_WIDTH     = $clog2(N_ENTRIES),
    localparam int REQ_IDX_WIDTH = $clog2(N_REQ),
    localparam int CNT_WIDTH     = $clog2(N_WRITE_PORTS + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst_aL,
    input  logic                                       flush,
    input  logic [N_REQ-1:0]                           req_valid,
    output logic [N_REQ-1:0]                           req_ready,
    input  logic [N_REQ-1:0][PTR_WIDTH-1:0]            req_addr,
    input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]          req_data,
    output logic [N_WRITE_PORTS-1:0]                   wr_en,
    output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr,
    output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]  wr_data,
    output logic [REQ_IDX_WIDTH-1:0]                   rr_ptr,
    output logic [CNT_WIDTH-1:0]                       grant_count
);

    logic [N_WRITE_PORTS-1:0]                   wr_en_d, wr_en_q;
    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr_d, wr_addr_q;
    logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]  wr_data_d, wr_data_q;
    logic [REQ_IDX_WIDTH-1:0]                   rr_ptr_d, rr_ptr_q;

    logic [N_WRITE_PORTS-1:0]                     port_vld;
    logic [N_WRITE_PORTS-1:0][REQ_IDX_WIDTH-1:0]  port_sel;
    logic [REQ_IDX_WIDTH-1:0]                     last_idx;
    int                                           cnt;
    int                                           idx;

    // Circular scan from rr_ptr; the k-th valid requester found binds port k.
    always_comb begin
        req_ready = '0;
        port_vld  = '0;
        port_sel  = '0;
        last_idx  = '0;
        cnt       = 0;
        idx       = 0;
        if (rst_aL && !flush) begin
            for (int j = 0; j < N_REQ; j++) begin
                idx = int'(rr_ptr_q) + j;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (req_valid[idx] && cnt < N_WRITE_PORTS) begin
                    req_ready[idx] = 1'b1;
                    port_vld[cnt]  = 1'b1;
                    port_sel[cnt]  = REQ_IDX_WIDTH'(idx);
                    last_idx       = REQ_IDX_WIDTH'(idx);
                    cnt            = cnt + 1;
                end
            end
        end
        grant_count = CNT_WIDTH'(cnt);
    end

    // Unbound ports keep their last addr/data; only wr_en drops.
    always_comb begin
        wr_en_d   = port_vld;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        for (int k = 0; k < N_WRITE_PORTS; k++) begin
            if (port_vld[k]) begin
                wr_addr_d[k] = req_addr[port_sel[k]];
                wr_data_d[k] = req_data[port_sel[k]];
            end
        end
        // Explicit wrap so non-power-of-2 N_REQ still cycles correctly.
        if (cnt > 0) begin
            if (last_idx == REQ_IDX_WIDTH'(N_REQ - 1))
                rr_ptr_d = '0;
            else
                rr_ptr_d = last_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb_rob_wb_arbiter: directed-vector bench for rob_wb_arbiter.
// Drives one scenario per task and compares against hand-computed values.
module tb_rob_wb_arbiter;

    logic             clk;
    logic             rst_aL;
    logic             flush;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][2:0]  req_addr;
    logic [3:0][31:0] req_data;
    logic [1:0]       wr_en;
    logic [1:0][2:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic [1:0]       rr_ptr;
    logic [1:0]       grant_count;

    int vectors = 0;
    int errors  = 0;

    rob_wb_arbiter dut (
        .clk         (clk),
        .rst_aL      (rst_aL),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rr_ptr      (rr_ptr),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_aL    = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 3'(i);
            req_data[i] = 32'hA000_0000 + 32'(i);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (req_ready !== 4'b0000 || wr_en !== 2'b00 ||
                rr_ptr !== 2'd0 || grant_count !== 2'd0) begin
                errors++;
                $display("FAIL reset c%0d: ready=%b wr_en=%b ptr=%0d cnt=%0d want 0000/00/0/0",
                         c, req_ready, wr_en, rr_ptr, grant_count);
            end
        end
        rst_aL = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0011 || grant_count !== 2'd2) begin
            errors++;
            $display("FAIL reset_release: ready=%b cnt=%0d want 0011/2",
                     req_ready, grant_count);
        end
    endtask

    task automatic test_rotate();
        tick();
        vectors++;
        if (wr_en !== 2'b11 || wr_addr[0] !== 3'd0 || wr_addr[1] !== 3'd1 ||
            wr_data[0] !== 32'hA000_0000 || wr_data[1] !== 32'hA000_0001 ||
            rr_ptr !== 2'd2) begin
            errors++;
            $display("FAIL rotate_c1: wr_en=%b addr=%0d,%0d data=%h,%h ptr=%0d want 11/0,1/a0000000,a0000001/2",
                     wr_en, wr_addr[0], wr_addr[1], wr_data[0], wr_data[1], rr_ptr);
        end
        vectors++;
        if (req_ready !== 4'b1100) begin
            errors++;
            $display("FAIL rotate_ready: ready=%b want 1100", req_ready);
        end
        tick();
        vectors++;
        if (wr_en !== 2'b11 || wr_addr[0] !== 3'd2 || wr_addr[1] !== 3'd3 ||
            rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL rotate_c2: wr_en=%b addr=%0d,%0d ptr=%0d want 11/2,3/0",
                     wr_en, wr_addr[0], wr_addr[1], rr_ptr);
        end
    endtask

    task automatic test_single_wrap();
        req_valid = 4'b0001;
        tick();
        vectors++;
        if (rr_ptr !== 2'd1 || wr_en !== 2'b01 || wr_addr[1] !== 3'd3) begin
            errors++;
            $display("FAIL single_setup: ptr=%0d wr_en=%b addr1=%0d want 1/01/3",
                     rr_ptr, wr_en, wr_addr[1]);
        end
        req_valid   = 4'b1000;
        req_data[3] = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (req_ready !== 4'b1000 || grant_count !== 2'd1) begin
            errors++;
            $display("FAIL single_ready: ready=%b cnt=%0d want 1000/1",
                     req_ready, grant_count);
        end
        tick();
        vectors++;
        if (wr_en !== 2'b01 || wr_data[0] !== 32'hDEAD_BEEF ||
            wr_addr[0] !== 3'd3 || wr_addr[1] !== 3'd3 || rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL single_wrap: wr_en=%b data0=%h addr=%0d,%0d ptr=%0d want 01/deadbeef/3,3/0",
                     wr_en, wr_data[0], wr_addr[0], wr_addr[1], rr_ptr);
        end
    endtask

    task automatic test_circular();
        req_valid = 4'b0100;
        tick();
        vectors++;
        if (rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL circ_setup: ptr=%0d want 3", rr_ptr);
        end
        req_valid = 4'b0101;
        #1;
        vectors++;
        if (req_ready !== 4'b0101 || grant_count !== 2'd2) begin
            errors++;
            $display("FAIL circ_ready: ready=%b cnt=%0d want 0101/2",
                     req_ready, grant_count);
        end
        tick();
        vectors++;
        if (wr_en !== 2'b11 || wr_addr[0] !== 3'd0 || wr_addr[1] !== 3'd2 ||
            rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL circ_write: wr_en=%b addr=%0d,%0d ptr=%0d want 11/0,2/3",
                     wr_en, wr_addr[0], wr_addr[1], rr_ptr);
        end
    endtask

    task automatic test_flush();
        req_valid = 4'b1111;
        flush     = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000 || grant_count !== 2'd0) begin
            errors++;
            $display("FAIL flush_ready: ready=%b cnt=%0d want 0000/0",
                     req_ready, grant_count);
        end
        tick();
        vectors++;
        if (wr_en !== 2'b00 || rr_ptr !== 2'd3 ||
            wr_addr[0] !== 3'd0 || wr_addr[1] !== 3'd2) begin
            errors++;
            $display("FAIL flush_write: wr_en=%b ptr=%0d addr=%0d,%0d want 00/3/0,2",
                     wr_en, rr_ptr, wr_addr[0], wr_addr[1]);
        end
        flush = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b1001) begin
            errors++;
            $display("FAIL flush_resume_ready: ready=%b want 1001", req_ready);
        end
        tick();
        vectors++;
        if (wr_en !== 2'b11 || wr_addr[0] !== 3'd3 || wr_addr[1] !== 3'd0 ||
            rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL flush_resume: wr_en=%b addr=%0d,%0d ptr=%0d want 11/3,0/1",
                     wr_en, wr_addr[0], wr_addr[1], rr_ptr);
        end
    endtask

    task automatic test_fairness();
        int ptr;
        int gap;
        logic [3:0] exp_ready;
        ptr = 1;
        gap = 0;
        for (int c = 0; c < 10; c++) begin
            exp_ready = '0;
            exp_ready[ptr]           = 1'b1;
            exp_ready[(ptr + 1) % 4] = 1'b1;
            vectors++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL fair_ready c%0d: ready=%b want %b",
                         c, req_ready, exp_ready);
            end
            if (req_ready[0]) gap = 0;
            else gap++;
            vectors++;
            if (gap >= 2) begin
                errors++;
                $display("FAIL fair_starve c%0d: req0 ungranted for %0d cycles want <2",
                         c, gap);
            end
            tick();
            vectors++;
            if (wr_en !== 2'b11 || wr_addr[0] !== 3'(ptr) ||
                wr_addr[1] !== 3'((ptr + 1) % 4)) begin
                errors++;
                $display("FAIL fair_write c%0d: wr_en=%b addr=%0d,%0d want 11/%0d,%0d",
                         c, wr_en, wr_addr[0], wr_addr[1], ptr, (ptr + 1) % 4);
            end
            ptr = (ptr + 2) % 4;
        end
    endtask

    task automatic test_reset_midburst();
        rst_aL = 1'b0;
        tick();
        vectors++;
        if (wr_en !== 2'b00 || wr_addr !== '0 || wr_data !== '0 ||
            rr_ptr !== 2'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: wr_en=%b addr=%h data=%h ptr=%0d ready=%b want all zero",
                     wr_en, wr_addr, wr_data, rr_ptr, req_ready);
        end
        rst_aL = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_single_wrap();
        test_circular();
        test_flush();
        test_fairness();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
